// File: rtl/norm_pkg.sv
// norm_pkg: shared FSM state type and direction encodings for seq_normalizer.
//   state_t   : IDLE (waiting for operand), SHIFT (one step per cycle), DONE (result held)
//   DIR_LEFT  : count leading zeros, shift toward the MSB
//   DIR_RIGHT : count trailing zeros, shift toward the LSB
package norm_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/norm_step.sv
// norm_step: one combinational normalization step (coarse, single or none).
//   opnd : current working operand
//   dir  : DIR_LEFT / DIR_RIGHT
//   nxt  : operand after this step (unchanged when done)
//   amt  : bit positions shifted by this step (0, 1 or COARSE)
//   done : operand is zero or already has its lead bit set
//   zero : operand is all-zero
module norm_step
    import norm_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int COARSE = 8,
    localparam int CW    = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] opnd,
    input  logic             dir,
    output logic [WIDTH-1:0] nxt,
    output logic [CW-1:0]    amt,
    output logic             done,
    output logic             zero
);

    logic lead;
    logic coarse_zero;

    assign zero        = (opnd == '0);
    assign lead        = (dir == DIR_RIGHT) ? opnd[0] : opnd[WIDTH-1];
    assign coarse_zero = (dir == DIR_RIGHT) ? (opnd[COARSE-1:0] == '0)
                                            : (opnd[WIDTH-1 -: COARSE] == '0);
    assign done        = zero || lead;

    // Two fixed shifters instead of one variable barrel: only 1 and COARSE are ever needed.
    always_comb begin
        nxt = opnd;
        amt = '0;
        if (!done) begin
            amt = coarse_zero ? CW'(COARSE) : CW'(1);
            nxt = coarse_zero ? ((dir == DIR_RIGHT) ? (opnd >> COARSE) : (opnd << COARSE))
                              : ((dir == DIR_RIGHT) ? (opnd >> 1) : (opnd << 1));
        end
    end

endmodule

// File: rtl/seq_normalizer.sv
// seq_normalizer: iterative leading/trailing-zero normalizer with valid/ready handshakes.
//   clk, rst_n          : clock, synchronous active-low reset
//   in_valid, in_ready  : operand handshake (in_ready only in IDLE)
//   A, Dir              : operand and direction, sampled at the accept edge only
//   out_valid, out_ready: result handshake (out_valid only in DONE)
//   Y, Cnt, Zero        : normalized operand, shift count, all-zero flag (registered)
module seq_normalizer
    import norm_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int COARSE = 8,
    localparam int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic             Dir,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Y,
    output logic [CW-1:0]    Cnt,
    output logic             Zero
);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] opnd;
    logic             dir;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] step_nxt;
    logic [CW-1:0]    step_amt;
    logic             step_done;
    logic             step_zero;

    norm_step #(.WIDTH(WIDTH), .COARSE(COARSE)) u_step (
        .opnd (opnd),
        .dir  (dir),
        .nxt  (step_nxt),
        .amt  (step_amt),
        .done (step_done),
        .zero (step_zero)
    );

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = SHIFT;
            SHIFT:   if (step_done) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs load only on completion so they stay frozen through SHIFT and DONE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            opnd  <= '0;
            dir   <= DIR_LEFT;
            cnt   <= '0;
            Y     <= '0;
            Cnt   <= '0;
            Zero  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && in_valid) begin
                opnd <= A;
                dir  <= Dir;
                cnt  <= '0;
            end
            if (state == SHIFT) begin
                if (step_done) begin
                    Y    <= step_zero ? '0 : opnd;
                    Cnt  <= step_zero ? CW'(WIDTH) : cnt;
                    Zero <= step_zero;
                end else begin
                    opnd <= step_nxt;
                    cnt  <= cnt + step_amt;
                end
            end
        end
    end

endmodule
